// File: rtl/rsa_privkey_calc_if.sv
// Request/result bundle between the key-material producer and rsa_privkey_calc.
// The master drives the prime pair and exponent; the slave returns phi, d and status.
interface rsa_privkey_calc_if #(
  parameter int W  = 14,
  parameter int PW = 7
);
  logic          start;
  logic [PW-1:0] p;
  logic [PW-1:0] q;
  logic [W-1:0]  e;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  phi;
  logic [W-1:0]  d;

  modport master (output start, p, q, e, input busy, done, err, phi, d);
  modport slave  (input start, p, q, e, output busy, done, err, phi, d);
endinterface

// File: rtl/rsa_privkey_calc.sv
// Computes phi = (p-1)(q-1) and d = e^-1 mod phi with a one-step-per-cycle
// extended Euclid FSM; invalid key material raises err and forces d = 0.
module rsa_privkey_calc #(
  parameter int W         = 14,
  parameter int PW        = 7,
  parameter int MAX_STEPS = 24
) (
  input logic                clk,
  input logic                rst,
  rsa_privkey_calc_if.slave  bus
);
  localparam int SW = $clog2(MAX_STEPS + 1);

  typedef enum logic [2:0] {IDLE, PHI, CHECK, EUCLID, FIN} state_t;

  state_t              state;
  logic [PW-1:0]       p_r, q_r;
  logic [W-1:0]        e_r, phi_r;
  logic [W-1:0]        r0, r1;
  logic signed [W:0]   t0, t1;
  logic [SW-1:0]       steps;

  logic [W-1:0]        qt, r_next, d_fin, phi_calc;
  logic signed [W:0]   t_next, t_fix;
  logic [PW-1:0]       pm1, qm1;
  logic                bad;

  always_comb begin
    qt = '0;
    if (r1 != '0) qt = r0 / r1;
  end

  assign r_next   = r0 - qt * r1;
  assign t_next   = t0 - $signed({1'b0, qt}) * t1;
  // A negative Bezout coefficient is folded back into [0, phi).
  assign t_fix    = t0 + $signed({1'b0, phi_r});
  assign d_fin    = t0[W] ? t_fix[W-1:0] : t0[W-1:0];
  assign pm1      = p_r - PW'(1);
  assign qm1      = q_r - PW'(1);
  assign phi_calc = {{(W-PW){1'b0}}, pm1} * {{(W-PW){1'b0}}, qm1};
  assign bad      = (p_r < PW'(2)) | (q_r < PW'(2)) | (e_r < W'(2)) | (e_r >= phi_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      p_r      <= '0;
      q_r      <= '0;
      e_r      <= '0;
      phi_r    <= '0;
      r0       <= '0;
      r1       <= '0;
      t0       <= '0;
      t1       <= '0;
      steps    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      bus.phi  <= '0;
      bus.d    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          p_r      <= bus.p;
          q_r      <= bus.q;
          e_r      <= bus.e;
          steps    <= '0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b1;
          state    <= PHI;
        end
        PHI: begin
          phi_r <= phi_calc;
          state <= CHECK;
        end
        CHECK: if (bad) begin
          bus.err  <= 1'b1;
          bus.done <= 1'b1;
          bus.phi  <= phi_r;
          bus.d    <= '0;
          state    <= FIN;
        end else begin
          r0    <= phi_r;
          r1    <= e_r;
          t0    <= '0;
          t1    <= (W+1)'(1);
          state <= EUCLID;
        end
        EUCLID: if (r1 == '0) begin
          // r0 now holds gcd(phi, e); only gcd 1 yields an inverse.
          bus.err  <= (r0 != W'(1));
          bus.d    <= (r0 != W'(1)) ? '0 : d_fin;
          bus.phi  <= phi_r;
          bus.done <= 1'b1;
          state    <= FIN;
        end else if (steps == SW'(MAX_STEPS)) begin
          bus.err  <= 1'b1;
          bus.d    <= '0;
          bus.phi  <= phi_r;
          bus.done <= 1'b1;
          state    <= FIN;
        end else begin
          r0    <= r1;
          r1    <= r_next;
          t0    <= t1;
          t1    <= t_next;
          steps <= steps + SW'(1);
        end
        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_privkey_calc.sv
// Self-checking bench for rsa_privkey_calc: directed key cases, start/reset
// corner cases and randomized keys against an integer extended-Euclid model.
module tb_rsa_privkey_calc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  rsa_privkey_calc_if #(.W(14), .PW(7)) bif ();

  rsa_privkey_calc #(.W(14), .PW(7), .MAX_STEPS(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the mathematical definition.
  function automatic void model(input int p, input int q, input int e,
                                output int phi, output int d, output int err, output int lat);
    int a, b, x0, x1, qq, tmp, k;
    phi = (((p - 1) & 127) * ((q - 1) & 127)) % 16384;
    if (p < 2 || q < 2 || e < 2 || e >= phi) begin
      err = 1; d = 0; lat = 3;
      return;
    end
    a = phi; b = e; x0 = 0; x1 = 1; k = 0;
    while (b != 0) begin
      qq = a / b;
      tmp = a - qq * b; a = b; b = tmp;
      tmp = x0 - qq * x1; x0 = x1; x1 = tmp;
      k++;
    end
    lat = 4 + k;
    if (a != 1) begin err = 1; d = 0; end
    else begin err = 0; d = ((x0 % phi) + phi) % phi; end
  endfunction

  // Drives one request and observes the response window (no checking here).
  task automatic run_op(input int p, input int q, input int e,
                        output int lat, output int ophi, output int od, output int oerr,
                        output int busy_cyc, output int done_cnt);
    @(negedge clk);
    bif.start = 1'b1; bif.p = 7'(p); bif.q = 7'(q); bif.e = 14'(e);
    @(negedge clk);
    bif.start = 1'b0;
    lat = -1; ophi = -1; od = -1; oerr = -1; busy_cyc = 0; done_cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      if (bif.busy) busy_cyc++;
      if (bif.done) begin
        if (lat < 0) begin
          lat = c; ophi = int'(bif.phi); od = int'(bif.d); oerr = int'(bif.err);
        end
        done_cnt++;
      end
      if (lat > 0 && c >= lat + 3) break;
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({bif.busy, bif.done, bif.err, bif.phi, bif.d} !== '0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b phi=%0d d=%0d, need all 0",
               bif.busy, bif.done, bif.err, bif.phi, bif.d);
    end
  endtask

  task automatic test_known;
    int lat, phi, d, err, bc, dc;
    run_op(61, 53, 17, lat, phi, d, err, bc, dc);
    tests++; if (lat !== 8)    begin fails++; $display("FAIL known_latency: got %0d need 8", lat); end
    tests++; if (phi !== 3120) begin fails++; $display("FAIL known_phi: got %0d need 3120", phi); end
    tests++; if (d !== 2753)   begin fails++; $display("FAIL known_d: got %0d need 2753", d); end
    tests++; if (err !== 0)    begin fails++; $display("FAIL known_err: got %0d need 0", err); end
    tests++; if (bc !== 8)     begin fails++; $display("FAIL known_busy_cycles: got %0d need 8", bc); end
  endtask

  task automatic test_small;
    int lat, phi, d, err, bc, dc;
    run_op(11, 13, 7, lat, phi, d, err, bc, dc);
    tests++; if (phi !== 120 || d !== 103 || err !== 0) begin
      fails++; $display("FAIL small_key: got phi=%0d d=%0d err=%0d need 120/103/0", phi, d, err);
    end
    tests++; if ((7 * d) % 120 !== 1) begin
      fails++; $display("FAIL small_inverse: got (7*d)%%120=%0d need 1", (7 * d) % 120);
    end
  endtask

  task automatic test_gcd_err;
    int lat, phi, d, err, bc, dc;
    run_op(11, 13, 6, lat, phi, d, err, bc, dc);
    tests++; if (err !== 1 || d !== 0 || phi !== 120) begin
      fails++; $display("FAIL gcd_err: got err=%0d d=%0d phi=%0d need 1/0/120", err, d, phi);
    end
    tests++; if (dc !== 1) begin fails++; $display("FAIL gcd_single_done: got %0d pulses need 1", dc); end
  endtask

  task automatic test_check_err;
    int lat, phi, d, err, bc, dc;
    run_op(11, 13, 120, lat, phi, d, err, bc, dc);
    tests++; if (lat !== 3 || err !== 1 || d !== 0 || phi !== 120) begin
      fails++; $display("FAIL e_ge_phi: got lat=%0d err=%0d d=%0d phi=%0d need 3/1/0/120", lat, err, d, phi);
    end
    run_op(1, 13, 7, lat, phi, d, err, bc, dc);
    tests++; if (lat !== 3 || err !== 1 || d !== 0 || phi !== 0) begin
      fails++; $display("FAIL p_lt_2: got lat=%0d err=%0d d=%0d phi=%0d need 3/1/0/0", lat, err, d, phi);
    end
  endtask

  task automatic test_ignore_start;
    int lat = -1, od = -1, lat2, phi, d, err, bc, dc;
    @(negedge clk);
    bif.start = 1'b1; bif.p = 7'd61; bif.q = 7'd53; bif.e = 14'd17;
    @(negedge clk);
    bif.start = 1'b0; bif.p = 7'd11; bif.q = 7'd13; bif.e = 14'd7;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (c > 1) @(negedge clk);
      bif.start = (c == 2);
      if (bif.done) begin lat = c; od = int'(bif.d); end
    end
    bif.start = 1'b0;
    tests++; if (lat !== 8 || od !== 2753) begin
      fails++; $display("FAIL ignore_start: got lat=%0d d=%0d need 8/2753", lat, od);
    end
    run_op(11, 13, 7, lat2, phi, d, err, bc, dc);
    tests++; if (lat2 !== 6 || d !== 103) begin
      fails++; $display("FAIL start_after_done: got lat=%0d d=%0d need 6/103", lat2, d);
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0, lat, phi, d, err, bc, dc;
    @(negedge clk);
    bif.start = 1'b1; bif.p = 7'd61; bif.q = 7'd53; bif.e = 14'd17;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if ({bif.busy, bif.done, bif.err, bif.phi, bif.d} !== '0) begin
      fails++; $display("FAIL reset_mid_async: got busy=%b done=%b err=%b phi=%0d d=%0d need all 0",
                        bif.busy, bif.done, bif.err, bif.phi, bif.d);
    end
    @(negedge clk); rst = 1'b0;
    repeat (12) begin @(negedge clk); if (bif.done || bif.busy) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL reset_no_done: got %0d active cycles need 0", seen); end
    run_op(61, 53, 17, lat, phi, d, err, bc, dc);
    tests++; if (d !== 2753 || err !== 0 || lat !== 8) begin
      fails++; $display("FAIL after_reset: got d=%0d err=%0d lat=%0d need 2753/0/8", d, err, lat);
    end
  endtask

  task automatic test_random;
    int primes[$] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53,
                      59, 61, 67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127};
    int p, q, e, xphi, xd, xerr, xlat, lat, phi, d, err, bc, dc;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        p = $urandom_range(0, 127); q = $urandom_range(0, 127);
      end else begin
        p = primes[$urandom_range(0, primes.size() - 1)];
        q = primes[$urandom_range(0, primes.size() - 1)];
      end
      model(p, q, 0, xphi, xd, xerr, xlat);
      e = (i % 5 == 4 || xphi < 3) ? int'($urandom_range(0, 16383)) : int'($urandom_range(2, xphi - 1));
      model(p, q, e, xphi, xd, xerr, xlat);
      run_op(p, q, e, lat, phi, d, err, bc, dc);
      tests++;
      if (lat !== xlat || phi !== xphi || d !== xd || err !== xerr || dc !== 1) begin
        fails++;
        $display("FAIL random[%0d] p=%0d q=%0d e=%0d: got lat=%0d phi=%0d d=%0d err=%0d done=%0d need %0d/%0d/%0d/%0d/1",
                 i, p, q, e, lat, phi, d, err, dc, xlat, xphi, xd, xerr);
      end
    end
  endtask

  initial begin
    bif.start = 1'b0; bif.p = '0; bif.q = '0; bif.e = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_known;
    test_small;
    test_gcd_err;
    test_check_err;
    test_ignore_start;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
